// File: rtl/axi_lite_reg_ctrl_if.sv
// AXI4-Lite channel bundle between a host master and the register controller slave.
interface axi_lite_reg_ctrl_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_ctrl.sv
// AXI4-Lite slave that serialises host reads/writes onto a single-port register bus,
// one access at a time, with round-robin read/write arbitration.
module axi_lite_reg_ctrl #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                aclk,
    input  logic                areset,
    axi_lite_reg_ctrl_if.slave  axi,
    output logic                reg_req,
    output logic                reg_we,
    output logic [ADDR_W-3:0]   reg_addr,
    output logic [31:0]         reg_wdata,
    output logic [3:0]          reg_wstrb,
    input  logic [31:0]         reg_rdata,
    input  logic                reg_err
);

    typedef enum logic [2:0] {
        StIdle,
        StWrAcc,
        StWrResp,
        StRdAcc,
        StRdWait,
        StRdResp
    } state_e;

    state_e      state_q, state_d;
    logic        last_rd_q, last_rd_d;

    logic        aw_held_q, w_held_q, ar_held_q;
    logic [31:0] awaddr_q, wdata_q, araddr_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;

    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic        wr_pend, rd_pend;
    logic        aw_oor, ar_oor;

    assign axi.awready = !aw_held_q && !areset;
    assign axi.wready  = !w_held_q && !areset;
    assign axi.arready = !ar_held_q && !areset;
    assign axi.bvalid  = (state_q == StWrResp);
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = (state_q == StRdResp);
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

    assign aw_hs = axi.awvalid && !aw_held_q;
    assign w_hs  = axi.wvalid && !w_held_q;
    assign ar_hs = axi.arvalid && !ar_held_q;
    assign b_hs  = (state_q == StWrResp) && axi.bready;
    assign r_hs  = (state_q == StRdResp) && axi.rready;

    assign wr_pend = aw_held_q && w_held_q;
    assign rd_pend = ar_held_q;

    // Anything above the decoded window is an error and never reaches the bank.
    assign aw_oor = |awaddr_q[31:ADDR_W];
    assign ar_oor = |araddr_q[31:ADDR_W];

    logic unused_bits;
    assign unused_bits = ^{axi.awprot, axi.arprot, awaddr_q[1:0], araddr_q[1:0]};

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= StIdle;
            last_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        reg_wstrb = '0;
        unique case (state_q)
            StIdle: begin
                // On a tie, last_rd_q picks the write; otherwise serve whichever is pending.
                if (wr_pend && (!rd_pend || last_rd_q)) begin
                    state_d   = StWrAcc;
                    last_rd_d = 1'b0;
                end else if (rd_pend) begin
                    state_d   = StRdAcc;
                    last_rd_d = 1'b1;
                end
            end
            StWrAcc: begin
                if (!aw_oor) begin
                    reg_req   = 1'b1;
                    reg_we    = 1'b1;
                    reg_addr  = awaddr_q[ADDR_W-1:2];
                    reg_wdata = wdata_q;
                    reg_wstrb = wstrb_q;
                end
                state_d = StWrResp;
            end
            StWrResp: begin
                if (axi.bready) begin
                    state_d = StIdle;
                end
            end
            StRdAcc: begin
                if (!ar_oor) begin
                    reg_req  = 1'b1;
                    reg_addr = araddr_q[ADDR_W-1:2];
                end
                state_d = StRdWait;
            end
            StRdWait: begin
                state_d = StRdResp;
            end
            StRdResp: begin
                if (axi.rready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            ar_held_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= axi.awaddr;
            end else if (b_hs) begin
                aw_held_q <= 1'b0;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= axi.wdata;
                wstrb_q  <= axi.wstrb;
            end else if (b_hs) begin
                w_held_q <= 1'b0;
            end
            if (ar_hs) begin
                ar_held_q <= 1'b1;
                araddr_q  <= axi.araddr;
            end else if (r_hs) begin
                ar_held_q <= 1'b0;
            end
            if (state_q == StWrAcc) begin
                bresp_q <= (aw_oor || reg_err) ? 2'b10 : 2'b00;
            end
            // Bank read data and error arrive the cycle after the strobe.
            if (state_q == StRdWait) begin
                rdata_q <= ar_oor ? 32'h0 : reg_rdata;
                rresp_q <= (ar_oor || reg_err) ? 2'b10 : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_ctrl.sv
// Self-checking bench for axi_lite_reg_ctrl: scenario tasks with a queue-based scoreboard.
module tb_axi_lite_reg_ctrl;
    localparam int unsigned ADDR_W = 8;

    logic              aclk;
    logic              areset;
    logic              reg_req;
    logic              reg_we;
    logic [ADDR_W-3:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic [3:0]        reg_wstrb;
    logic [31:0]       reg_rdata;
    logic              reg_err;

    axi_lite_reg_ctrl_if bus ();

    axi_lite_reg_ctrl #(.ADDR_W(ADDR_W)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .axi       (bus),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_rdata (reg_rdata),
        .reg_err   (reg_err)
    );

    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    acc_t       exp_acc[$];
    logic [1:0] exp_b[$];
    rsp_t       exp_r[$];

    int checks = 0;
    int errors = 0;

    // Register bank model: read data and read error appear one cycle after the strobe.
    logic [31:0] bank_val;
    logic        err_on_read;
    logic        err_on_write;
    logic        rd_d1;

    always @(posedge aclk) begin
        if (areset) rd_d1 <= 1'b0;
        else        rd_d1 <= reg_req && !reg_we;
    end

    assign reg_rdata = rd_d1 ? bank_val : 32'h0;
    assign reg_err   = (rd_d1 && err_on_read) || (reg_req && reg_we && err_on_write);

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_idle();
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_readies: got %b expected 000",
                     {bus.awready, bus.wready, bus.arready});
        end
        checks++;
        if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata} !== 38'h0) begin
            errors++;
            $display("FAIL reset_resp: got bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h expected all 0",
                     bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata);
        end
        checks++;
        if ({reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb} !== 44'h0) begin
            errors++;
            $display("FAIL reset_regbus: got req=%b we=%b addr=%h wdata=%h wstrb=%h expected all 0",
                     reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb);
        end
        areset = 1'b0;
        tick();
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            errors++;
            $display("FAIL post_reset_readies: got %b expected 111",
                     {bus.awready, bus.wready, bus.arready});
        end
    endtask

    task automatic test_write_basic();
        acc_t       a;
        logic [1:0] e;
        bus.awaddr  = 32'h10;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'hDEADBEEF;
        bus.wstrb   = 4'hF;
        bus.wvalid  = 1'b1;
        exp_acc.push_back({1'b1, 6'd4, 32'hDEADBEEF, 4'hF});
        exp_b.push_back(2'b00);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        checks++;
        if ({reg_req, bus.awready, bus.wready} !== 3'b000) begin
            errors++;
            $display("FAIL wr_cycle1: got req/awready/wready=%b expected 000",
                     {reg_req, bus.awready, bus.wready});
        end
        tick();
        a = exp_acc.pop_front();
        checks++;
        if ({reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb} !== {1'b1, a}) begin
            errors++;
            $display("FAIL wr_access: got req=%b we=%b addr=%0d wdata=%h wstrb=%h expected 1 %b %0d %h %h",
                     reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb, a.we, a.addr, a.wdata, a.wstrb);
        end
        tick();
        e = exp_b.pop_front();
        checks++;
        if ({reg_req, bus.bvalid, bus.bresp} !== {2'b01, e}) begin
            errors++;
            $display("FAIL wr_bresp: got req=%b bvalid=%b bresp=%b expected 0 1 %b",
                     reg_req, bus.bvalid, bus.bresp, e);
        end
        tick();
        checks++;
        if (bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_bvalid_once: got bvalid=%b expected 0", bus.bvalid);
        end
    endtask

    task automatic test_w_before_aw();
        acc_t       a;
        logic [1:0] e;
        logic       bad;
        bus.wdata  = 32'hA5A50001;
        bus.wstrb  = 4'h3;
        bus.wvalid = 1'b1;
        exp_acc.push_back({1'b1, 6'd1, 32'hA5A50001, 4'h3});
        exp_b.push_back(2'b00);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) bus.wvalid = 1'b0;
            if (bus.wready !== 1'b0 || reg_req !== 1'b0) bad = 1'b1;
            if (i == 2) begin
                bus.awaddr  = 32'h04;
                bus.awvalid = 1'b1;
            end
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL w_first_wait: got wready/req activity=%b expected 0", bad);
        end
        tick();
        bus.awvalid = 1'b0;
        checks++;
        if (reg_req !== 1'b0) begin
            errors++;
            $display("FAIL w_first_early_req: got req=%b expected 0", reg_req);
        end
        tick();
        a = exp_acc.pop_front();
        checks++;
        if ({reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb} !== {1'b1, a}) begin
            errors++;
            $display("FAIL w_first_access: got req=%b we=%b addr=%0d wdata=%h wstrb=%h expected 1 %b %0d %h %h",
                     reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb, a.we, a.addr, a.wdata, a.wstrb);
        end
        tick();
        e = exp_b.pop_front();
        checks++;
        if ({bus.bvalid, bus.bresp} !== {1'b1, e}) begin
            errors++;
            $display("FAIL w_first_bresp: got bvalid=%b bresp=%b expected 1 %b",
                     bus.bvalid, bus.bresp, e);
        end
        tick();
    endtask

    task automatic test_read_basic();
        acc_t a;
        rsp_t r;
        bank_val    = 32'h12345678;
        bus.araddr  = 32'h08;
        bus.arvalid = 1'b1;
        exp_acc.push_back({1'b0, 6'd2, 32'h0, 4'h0});
        exp_r.push_back({32'h12345678, 2'b00});
        tick();
        bus.arvalid = 1'b0;
        checks++;
        if ({reg_req, bus.arready} !== 2'b00) begin
            errors++;
            $display("FAIL rd_cycle1: got req/arready=%b expected 00", {reg_req, bus.arready});
        end
        tick();
        a = exp_acc.pop_front();
        checks++;
        if ({reg_req, reg_we, reg_addr} !== {1'b1, a.we, a.addr}) begin
            errors++;
            $display("FAIL rd_access: got req=%b we=%b addr=%0d expected 1 %b %0d",
                     reg_req, reg_we, reg_addr, a.we, a.addr);
        end
        tick();
        checks++;
        if ({reg_req, bus.rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rd_cycle3: got req/rvalid=%b expected 00", {reg_req, bus.rvalid});
        end
        tick();
        r = exp_r.pop_front();
        checks++;
        if ({bus.rvalid, bus.rdata, bus.rresp} !== {1'b1, r}) begin
            errors++;
            $display("FAIL rd_resp: got rvalid=%b rdata=%h rresp=%b expected 1 %h %b",
                     bus.rvalid, bus.rdata, bus.rresp, r.data, r.resp);
        end
        tick();
        checks++;
        if (bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_rvalid_once: got rvalid=%b expected 0", bus.rvalid);
        end
    endtask

    task automatic test_out_of_range();
        logic       any_req;
        logic [1:0] e;
        rsp_t       r;
        bank_val    = 32'hFFFFFFFF;
        bus.awaddr  = 32'h100;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'h55;
        bus.wstrb   = 4'hF;
        bus.wvalid  = 1'b1;
        exp_b.push_back(2'b10);
        any_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            any_req |= reg_req;
        end
        e = exp_b.pop_front();
        checks++;
        if ({bus.bvalid, bus.bresp} !== {1'b1, e}) begin
            errors++;
            $display("FAIL oor_bresp: got bvalid=%b bresp=%b expected 1 %b", bus.bvalid, bus.bresp, e);
        end
        tick();
        bus.araddr  = 32'h200;
        bus.arvalid = 1'b1;
        exp_r.push_back({32'h0, 2'b10});
        for (int i = 1; i <= 4; i++) begin
            tick();
            bus.arvalid = 1'b0;
            any_req |= reg_req;
        end
        r = exp_r.pop_front();
        checks++;
        if ({bus.rvalid, bus.rdata, bus.rresp} !== {1'b1, r}) begin
            errors++;
            $display("FAIL oor_rresp: got rvalid=%b rdata=%h rresp=%b expected 1 %h %b",
                     bus.rvalid, bus.rdata, bus.rresp, r.data, r.resp);
        end
        checks++;
        if (any_req !== 1'b0) begin
            errors++;
            $display("FAIL oor_no_req: got reg_req seen=%b expected 0", any_req);
        end
        tick();
    endtask

    task automatic test_boundary();
        acc_t       a;
        logic [1:0] e;
        // Top word, unaligned low bits, empty strobe, bank flags a write error.
        err_on_write = 1'b1;
        bus.awaddr   = 32'hFF;
        bus.awvalid  = 1'b1;
        bus.wdata    = 32'h0BADF00D;
        bus.wstrb    = 4'h0;
        bus.wvalid   = 1'b1;
        exp_acc.push_back({1'b1, 6'd63, 32'h0BADF00D, 4'h0});
        exp_b.push_back(2'b10);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        tick();
        a = exp_acc.pop_front();
        checks++;
        if ({reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb} !== {1'b1, a}) begin
            errors++;
            $display("FAIL bound_access: got req=%b we=%b addr=%0d wdata=%h wstrb=%h expected 1 %b %0d %h %h",
                     reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb, a.we, a.addr, a.wdata, a.wstrb);
        end
        tick();
        err_on_write = 1'b0;
        e = exp_b.pop_front();
        checks++;
        if ({bus.bvalid, bus.bresp} !== {1'b1, e}) begin
            errors++;
            $display("FAIL bound_bresp: got bvalid=%b bresp=%b expected 1 %b", bus.bvalid, bus.bresp, e);
        end
        tick();
    endtask

    task automatic test_tie();
        acc_t       a;
        logic [1:0] e;
        rsp_t       r;
        logic       done;
        do_reset();
        bank_val = 32'hCAFE0005;
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 0) begin
                err_on_read = 1'b1;
                exp_acc.push_back({1'b1, 6'd8, 32'h11112222, 4'hF});
                exp_acc.push_back({1'b0, 6'd5, 32'h0, 4'h0});
                exp_b.push_back(2'b00);
                exp_r.push_back({32'hCAFE0005, 2'b10});
                bus.awaddr = 32'h20; bus.wdata = 32'h11112222; bus.wstrb = 4'hF;
                bus.araddr = 32'h14;
                bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
            end else if (ph == 1) begin
                err_on_read = 1'b0;
                exp_acc.push_back({1'b1, 6'd9, 32'h33334444, 4'hF});
                exp_b.push_back(2'b00);
                bus.awaddr = 32'h24; bus.wdata = 32'h33334444; bus.wstrb = 4'hF;
                bus.awvalid = 1'b1; bus.wvalid = 1'b1;
            end else begin
                // Last grant went to a write, so this tie must go to the read.
                exp_acc.push_back({1'b0, 6'd5, 32'h0, 4'h0});
                exp_acc.push_back({1'b1, 6'd10, 32'h55556666, 4'h3});
                exp_r.push_back({32'hCAFE0005, 2'b00});
                exp_b.push_back(2'b00);
                bus.awaddr = 32'h28; bus.wdata = 32'h55556666; bus.wstrb = 4'h3;
                bus.araddr = 32'h14;
                bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
            end
            done = 1'b0;
            for (int i = 0; i < 40 && !done; i++) begin
                tick();
                bus.awvalid = 1'b0;
                bus.wvalid  = 1'b0;
                bus.arvalid = 1'b0;
                if (reg_req === 1'b1) begin
                    checks++;
                    if (exp_acc.size() == 0) begin
                        errors++;
                        $display("FAIL tie_extra_req: got we=%b addr=%0d expected no access", reg_we, reg_addr);
                    end else begin
                        a = exp_acc.pop_front();
                        if ({reg_we, reg_addr} !== {a.we, a.addr} ||
                            (a.we && {reg_wdata, reg_wstrb} !== {a.wdata, a.wstrb})) begin
                            errors++;
                            $display("FAIL tie_order ph%0d: got we=%b addr=%0d wdata=%h wstrb=%h expected %b %0d %h %h",
                                     ph, reg_we, reg_addr, reg_wdata, reg_wstrb, a.we, a.addr, a.wdata, a.wstrb);
                        end
                    end
                end
                if (bus.bvalid === 1'b1 && exp_b.size() != 0) begin
                    e = exp_b.pop_front();
                    checks++;
                    if (bus.bresp !== e) begin
                        errors++;
                        $display("FAIL tie_bresp ph%0d: got %b expected %b", ph, bus.bresp, e);
                    end
                end
                if (bus.rvalid === 1'b1 && exp_r.size() != 0) begin
                    r = exp_r.pop_front();
                    checks++;
                    if ({bus.rdata, bus.rresp} !== r) begin
                        errors++;
                        $display("FAIL tie_rresp ph%0d: got rdata=%h rresp=%b expected %h %b",
                                 ph, bus.rdata, bus.rresp, r.data, r.resp);
                    end
                end
                done = (exp_acc.size() == 0) && (exp_b.size() == 0) && (exp_r.size() == 0);
            end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL tie_timeout ph%0d: got pending acc=%0d b=%0d r=%0d expected 0 0 0",
                         ph, exp_acc.size(), exp_b.size(), exp_r.size());
                exp_acc.delete();
                exp_b.delete();
                exp_r.delete();
            end
            tick();
        end
    endtask

    task automatic test_backpressure_reset();
        rsp_t r;
        logic stable;
        logic bad;
        bank_val    = 32'h12345678;
        bus.rready  = 1'b0;
        bus.araddr  = 32'h08;
        bus.arvalid = 1'b1;
        exp_r.push_back({32'h12345678, 2'b00});
        for (int i = 1; i <= 4; i++) begin
            tick();
            bus.arvalid = 1'b0;
        end
        r = exp_r.pop_front();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if ({bus.rvalid, bus.rdata, bus.rresp} !== {1'b1, r}) stable = 1'b0;
            tick();
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable: got rvalid=%b rdata=%h rresp=%b expected 1 %h %b held",
                     bus.rvalid, bus.rdata, bus.rresp, r.data, r.resp);
        end
        bus.rready = 1'b1;
        tick();
        checks++;
        if (bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rvalid=%b expected 0", bus.rvalid);
        end

        bus.bready  = 1'b0;
        bus.awaddr  = 32'h30;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'h77778888;
        bus.wstrb   = 4'hF;
        bus.wvalid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end
        checks++;
        if (bus.bvalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_bvalid: got bvalid=%b expected 1", bus.bvalid);
        end
        areset = 1'b1;
        tick();
        checks++;
        if ({bus.bvalid, bus.awready, bus.wready, bus.arready} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid: got bvalid/awready/wready/arready=%b expected 0000",
                     {bus.bvalid, bus.awready, bus.wready, bus.arready});
        end
        areset = 1'b0;
        tick();
        checks++;
        if ({bus.bvalid, bus.awready, bus.wready, bus.arready} !== 4'b0111) begin
            errors++;
            $display("FAIL rst_release: got bvalid/awready/wready/arready=%b expected 0111",
                     {bus.bvalid, bus.awready, bus.wready, bus.arready});
        end
        bus.bready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.bvalid !== 1'b0 || reg_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard: got late response/access=%b expected 0", bad);
        end
    endtask

    initial begin
        areset       = 1'b1;
        bank_val     = 32'h0;
        err_on_read  = 1'b0;
        err_on_write = 1'b0;
        drive_idle();
        test_reset();
        test_write_basic();
        test_w_before_aw();
        test_read_basic();
        test_out_of_range();
        test_boundary();
        test_tie();
        test_backpressure_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
